// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: request/result bundle for alu_muldiv (start_i, ALUCtrl_i, src1_i, src2_i in; busy_o, done_o, hi_o, lo_o, div_zero_o out)
interface alu_muldiv_if #(parameter int DATA_W = 32);
  logic              start_i;
  logic [3:0]        ALUCtrl_i;
  logic [DATA_W-1:0] src1_i;
  logic [DATA_W-1:0] src2_i;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              div_zero_o;
  modport master (
    output start_i, ALUCtrl_i, src1_i, src2_i,
    input  busy_o, done_o, hi_o, lo_o, div_zero_o
  );
  modport slave (
    input  start_i, ALUCtrl_i, src1_i, src2_i,
    output busy_o, done_o, hi_o, lo_o, div_zero_o
  );
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative MULTU/MULT/DIVU/DIV unit; ports clk_i, rst_i (sync active-high), bus (alu_muldiv_if.slave); MULT/DIV enabled by ALU_MULDIV_SIGNED_EN
module alu_muldiv #(
  parameter int DATA_W = 32
) (
  input logic         clk_i,
  input logic         rst_i,
  alu_muldiv_if.slave bus
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t              state, state_n;
  logic [CW-1:0]       cnt;
  logic                is_div, div_zero, op_ok, accept, zero_div;
  logic [DATA_W-1:0]   b, rem, q, hi, lo, mag1, mag2, diff, quo, rmd;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W:0]     sum, shifted;
  logic                ge;
`ifdef ALU_MULDIV_SIGNED_EN
  logic s1, s2, neg_p, neg_r;
  assign op_ok = bus.ALUCtrl_i[3:2] == 2'b10;
  assign s1    = bus.ALUCtrl_i[0] & bus.src1_i[DATA_W-1];
  assign s2    = bus.ALUCtrl_i[0] & bus.src2_i[DATA_W-1];
  assign mag1  = s1 ? -bus.src1_i : bus.src1_i;
  assign mag2  = s2 ? -bus.src2_i : bus.src2_i;
  assign prod  = neg_p ? -{rem, q} : {rem, q};
  assign quo   = neg_p ? -q : q;
  assign rmd   = neg_r ? -rem : rem;
`else
  assign op_ok = bus.ALUCtrl_i[3:2] == 2'b10 && !bus.ALUCtrl_i[0];
  assign mag1  = bus.src1_i;
  assign mag2  = bus.src2_i;
  assign prod  = {rem, q};
  assign quo   = q;
  assign rmd   = rem;
`endif
  assign accept   = bus.start_i && state == IDLE && op_ok;
  assign zero_div = bus.ALUCtrl_i[1] && bus.src2_i == '0;
  assign sum      = {1'b0, rem} + {1'b0, q[0] ? b : '0};
  assign shifted  = {rem, q[DATA_W-1]};
  assign ge       = shifted >= {1'b0, b};
  assign diff     = shifted[DATA_W-1:0] - b;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (accept ? (zero_div ? DONE : CALC) : IDLE)
            : state == CALC ? (cnt == CW'(DATA_W - 1) ? FIX : CALC)
            : state == FIX  ? DONE : IDLE;
  end
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      is_div   <= bus.ALUCtrl_i[1];
      b        <= mag2;
      q        <= mag1;
      rem      <= '0;
      cnt      <= '0;
      div_zero <= zero_div;
`ifdef ALU_MULDIV_SIGNED_EN
      neg_p    <= s1 ^ s2;
      neg_r    <= s1;
`endif
      if (zero_div) begin
        hi <= bus.src1_i;
        lo <= '1;
      end
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      rem <= is_div ? (ge ? diff : shifted[DATA_W-1:0]) : sum[DATA_W:1];
      q   <= is_div ? {q[DATA_W-2:0], ge} : {sum[0], q[DATA_W-1:1]};
    end else if (state == FIX) begin
      {hi, lo} <= is_div ? {rmd, quo} : prod;
    end
  end
  assign bus.busy_o     = state != IDLE;
  assign bus.done_o     = state == DONE;
  assign bus.hi_o       = hi;
  assign bus.lo_o       = lo;
  assign bus.div_zero_o = div_zero;
endmodule
